axi_mem_responder: RTL and testbench

- Single-port, block-wide AXI responder (subordinate) that serves the single-beat read and write transactions issued by the load/store unit and fetch path.
- Sits on the opposite end of the memory interface from the LSU. Used as the backing memory in simulation and for on-chip scratch RAM.
- Accepts AR, or joint AW+W. Returns R or B. Handles one outstanding transaction at a time.

---
 rtl/axi_mem_responder_if.sv | 72 +++++++
 rtl/axi_mem_responder.sv | 148 ++++++++++++++
 tb/tb_axi_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// -----------------------------------------------------------------------------
// axi_mem_responder_if
//   Single-beat AXI bus between the LSU/fetch path (master) and the memory
//   responder (slave). Clock and reset are not carried here; they stay plain
//   ports on the modules that use this bus.
//
//   Channels:
//     AW : awvalid/awready, awid, awaddr, awlen
//     W  : wvalid/wready, wdata, wstrb, wlast
//     B  : bvalid/bready, bid, bresp
//     AR : arvalid/arready, arid, araddr, arlen
//     R  : rvalid/rready, rid, rdata, rresp, rlast
// -----------------------------------------------------------------------------
interface axi_mem_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128,
   parameter int ID_WIDTH   = 1
);
   logic                    awvalid;
   logic                    awready;
   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;

   logic                    wvalid;
   logic                    wready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;

   logic                    bvalid;
   logic                    bready;
   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;

   logic                    arvalid;
   logic                    arready;
   logic [ID_WIDTH-1:0]     arid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;

   logic                    rvalid;
   logic                    rready;
   logic [ID_WIDTH-1:0]     rid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;

   modport master (
      output awvalid, awid, awaddr, awlen,
      output wvalid, wdata, wstrb, wlast,
      output bready,
      output arvalid, arid, araddr, arlen,
      output rready,
      input  awready, wready,
      input  bvalid, bid, bresp,
      input  arready,
      input  rvalid, rid, rdata, rresp, rlast
   );

   modport slave (
      input  awvalid, awid, awaddr, awlen,
      input  wvalid, wdata, wstrb, wlast,
      input  bready,
      input  arvalid, arid, araddr, arlen,
      input  rready,
      output awready, wready,
      output bvalid, bid, bresp,
      output arready,
      output rvalid, rid, rdata, rresp, rlast
   );
endinterface

// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
//   Single-beat AXI subordinate backed by a DEPTH x DATA_WIDTH RAM. Serves one
//   transaction at a time: an AR, or an AW+W pair accepted in the same cycle.
//   The response is valid the cycle after acceptance and held until taken.
//   When AR and AW+W contend in IDLE, a priority bit alternates the winner.
//
//   Ports:
//     clk    : clock
//     rst_n  : asynchronous active-low reset (memory contents are not reset)
//     bus    : axi_mem_responder_if.slave (AW/W/B/AR/R channels)
//
//   Build option:
//     AXI_MEM_RESPONDER_RANGECHK_EN - addresses outside
//       [BASE_ADDR, BASE_ADDR + DEPTH*DATA_WIDTH/8) get DECERR with the write
//       suppressed and rdata=0. Without it, the index wraps modulo DEPTH.
// -----------------------------------------------------------------------------
module axi_mem_responder #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 128,
   parameter int                    ID_WIDTH   = 1,
   parameter int                    DEPTH      = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
   input  logic                clk,
   input  logic                rst_n,
   axi_mem_responder_if.slave  bus
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF    = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RD_RESP = 2'd1;
   localparam logic [1:0] ST_WR_RESP = 2'd2;

   localparam logic PRIO_RD = 1'b0;

   logic [1:0]            state;
   logic                  prio;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ID_WIDTH-1:0]   rid_q, bid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q, bresp_q;

   logic [ADDR_WIDTH-1:0] ar_off, aw_off;
   logic [IDX_W-1:0]      ar_idx, aw_idx;
   logic                  ar_oor, aw_oor;
   logic [1:0]            ar_resp, aw_resp;
   logic                  idle, wr_pair, grant_rd, grant_wr, mem_we;

   // Offsets are taken relative to BASE_ADDR; the byte-within-word bits are
   // dropped and only IDX_W bits select the word.
   assign ar_off = bus.araddr - BASE_ADDR;
   assign aw_off = bus.awaddr - BASE_ADDR;
   assign ar_idx = ar_off[OFF +: IDX_W];
   assign aw_idx = aw_off[OFF +: IDX_W];

`ifdef AXI_MEM_RESPONDER_RANGECHK_EN
   localparam logic [1:0]          RESP_DECERR = 2'b11;
   localparam logic [ADDR_WIDTH:0] SPAN        = (ADDR_WIDTH+1)'(DEPTH) << OFF;
   // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare
   // covers both ends of the window.
   assign ar_oor  = ({1'b0, ar_off} >= SPAN);
   assign aw_oor  = ({1'b0, aw_off} >= SPAN);
   // Bad length outranks out-of-range.
   assign ar_resp = (bus.arlen != 8'd0) ? RESP_SLVERR : (ar_oor ? RESP_DECERR : RESP_OKAY);
   assign aw_resp = (bus.awlen != 8'd0) ? RESP_SLVERR : (aw_oor ? RESP_DECERR : RESP_OKAY);
`else
   assign ar_oor  = 1'b0;
   assign aw_oor  = 1'b0;
   assign ar_resp = (bus.arlen != 8'd0) ? RESP_SLVERR : RESP_OKAY;
   assign aw_resp = (bus.awlen != 8'd0) ? RESP_SLVERR : RESP_OKAY;
`endif

   // Single beat only, so wlast carries nothing; the unused offset bits are
   // the byte lane and the wrapped-away high part.
   logic unused_ok;
   assign unused_ok = &{1'b0, bus.wlast, ar_off, aw_off, ar_oor, aw_oor};

   // AW and W are only ever taken together. Read wins unless a write pair is
   // also present and it is the write's turn.
   assign idle     = (state == ST_IDLE);
   assign wr_pair  = bus.awvalid && bus.wvalid;
   assign grant_rd = idle && bus.arvalid && (!wr_pair || prio == PRIO_RD);
   assign grant_wr = idle && wr_pair && !grant_rd;

   assign bus.arready = grant_rd;
   assign bus.awready = grant_wr;
   assign bus.wready  = grant_wr;

   assign bus.rvalid = (state == ST_RD_RESP);
   assign bus.bvalid = (state == ST_WR_RESP);
   assign bus.rid    = rid_q;
   assign bus.rdata  = rdata_q;
   assign bus.rresp  = rresp_q;
   assign bus.rlast  = 1'b1;
   assign bus.bid    = bid_q;
   assign bus.bresp  = bresp_q;

   // The write commits on the acceptance edge so a following read sees it.
   // Held off during reset so a grant seen while in reset cannot corrupt RAM.
   assign mem_we = grant_wr && rst_n && (aw_resp == RESP_OKAY);

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (bus.wstrb[b]) mem[aw_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         prio    <= PRIO_RD;
         rid_q   <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         bid_q   <= '0;
         bresp_q <= RESP_OKAY;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_rd) begin
                  rid_q   <= bus.arid;
                  rresp_q <= ar_resp;
                  rdata_q <= (ar_resp == RESP_OKAY) ? mem[ar_idx] : '0;
                  prio    <= ~prio;
                  state   <= ST_RD_RESP;
               end else if (grant_wr) begin
                  bid_q   <= bus.awid;
                  bresp_q <= aw_resp;
                  prio    <= ~prio;
                  state   <= ST_WR_RESP;
               end
            end
            ST_RD_RESP: if (bus.rready) state <= ST_IDLE;
            ST_WR_RESP: if (bus.bready) state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_responder
//   Directed bench for axi_mem_responder. Each accepted request pushes its
//   expected response (from a small memory/response model) onto a queue; the
//   response collector pops and compares. Inputs change on the falling edge,
//   outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_axi_mem_responder;
   localparam int          AW    = 32;
   localparam int          DW    = 128;
   localparam int          IW    = 1;
   localparam int          SW    = DW / 8;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h8000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   axi_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

   axi_mem_responder #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH), .BASE_ADDR(BASE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rd;
      logic [IW-1:0] id;
      logic [DW-1:0] data;
      logic [1:0]    resp;
   } exp_t;

   exp_t          sb[$];
   exp_t          dropped;
   logic [DW-1:0] mm [DEPTH];
   int            n_chk  = 0;
   int            n_pass = 0;
   int            n_fail = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] m_resp(input logic [7:0] len, input logic [31:0] addr);
      if (len != 8'd0) return 2'b10;
`ifdef AXI_MEM_RESPONDER_RANGECHK_EN
      if ((addr - BASE) >= 32'(DEPTH * SW)) return 2'b11;
`endif
      return 2'b00;
   endfunction

   function automatic int m_idx(input logic [31:0] addr);
      return int'(((addr - BASE) >> 4) & 32'(DEPTH - 1));
   endfunction

   task automatic push_rd(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len);
      exp_t e;
      e.rd   = 1'b1;
      e.id   = id;
      e.resp = m_resp(len, addr);
      e.data = (e.resp == 2'b00) ? mm[m_idx(addr)] : '0;
      sb.push_back(e);
   endtask

   task automatic push_wr(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [DW-1:0] data, input logic [SW-1:0] strb);
      exp_t e;
      e.rd   = 1'b0;
      e.id   = id;
      e.resp = m_resp(len, addr);
      e.data = '0;
      if (e.resp == 2'b00) begin
         for (int b = 0; b < SW; b++)
            if (strb[b]) mm[m_idx(addr)][b*8 +: 8] = data[b*8 +: 8];
      end
      sb.push_back(e);
   endtask

   task automatic wait_grant(input string tag, input bit rd);
      int n = 0;
      while (!(rd ? bus.arready : (bus.awready && bus.wready)) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check({tag, "_grant"}, n < 20, 1);
   endtask

   // Expects to be entered at negedge+1; leaves at negedge+1 after the handshake.
   task automatic collect(input string tag);
      exp_t e;
      int   n = 0;
      while (!(bus.rvalid || bus.bvalid) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check({tag, "_resp_seen"}, n < 20, 1);
      check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      if (e.rd) begin
         check({tag, "_rvalid"}, bus.rvalid, 1);
         check({tag, "_rid"},    bus.rid,    e.id);
         check({tag, "_rresp"},  bus.rresp,  e.resp);
         check({tag, "_rdata"},  bus.rdata,  e.data);
         check({tag, "_rlast"},  bus.rlast,  1);
         bus.rready = 1'b1;
      end else begin
         check({tag, "_bvalid"}, bus.bvalid, 1);
         check({tag, "_bid"},    bus.bid,    e.id);
         check({tag, "_bresp"},  bus.bresp,  e.resp);
         bus.bready = 1'b1;
      end
      @(negedge clk);
      bus.rready = 1'b0;
      bus.bready = 1'b0;
      #1;
      check({tag, "_valid_drop"}, bus.rvalid || bus.bvalid, 0);
   endtask

   task automatic rd(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                     input string tag);
      @(negedge clk);
      bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr; bus.arlen = len;
      #1;
      wait_grant(tag, 1);
      push_rd(id, addr, len);
      @(negedge clk);
      bus.arvalid = 1'b0;
      #1;
      check({tag, "_rd_latency"}, bus.rvalid, 1);
      collect(tag);
   endtask

   task automatic issue_wr(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [DW-1:0] data, input logic [SW-1:0] strb, input string tag);
      @(negedge clk);
      bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr; bus.awlen = len;
      bus.wvalid  = 1'b1; bus.wdata = data; bus.wstrb = strb; bus.wlast = 1'b1;
      #1;
      wait_grant(tag, 0);
      push_wr(id, addr, len, data, strb);
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      #1;
      check({tag, "_wr_latency"}, bus.bvalid, 1);
   endtask

   task automatic wr(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                     input logic [DW-1:0] data, input logic [SW-1:0] strb, input string tag);
      issue_wr(id, addr, len, data, strb, tag);
      collect(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d;
      bus.awvalid = 0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
      bus.wvalid  = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;
      bus.bready  = 0;
      bus.arvalid = 0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
      bus.rready  = 0;

      // Reset state
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_rvalid", bus.rvalid, 0);
      check("rst_bvalid", bus.bvalid, 0);
      check("rst_rdata",  bus.rdata,  0);
      check("rst_rresp",  bus.rresp,  0);
      check("rst_rid",    bus.rid,    0);
      check("rst_bid",    bus.bid,    0);
      check("rst_bresp",  bus.bresp,  0);
      @(negedge clk);
      rst_n = 1'b1;

      // Known contents for the words used below
      for (int i = 0; i < 4; i++) begin
         d = {4{32'(i + 1) * 32'h0101_0101}};
         wr(IW'(i & 1), BASE + 32'(i * 16), 8'd0, d, '1, "init");
      end

      // Lane-0 partial write then read back
      d = 128'h0;
      d[31:0] = 32'hDEAD_BEEF;
      wr(1'b1, 32'h8000_0010, 8'd0, d, 16'h000F, "beef_wr");
      rd(1'b1, 32'h8000_0010, 8'd0, "beef_rd");

      // wstrb = 0 leaves memory unchanged
      wr(1'b0, 32'h8000_0020, 8'd0, '1, 16'h0000, "strb0_wr");
      rd(1'b0, 32'h8000_0020, 8'd0, "strb0_rd");

      // Bad write length: SLVERR and no write
      wr(1'b1, 32'h8000_0020, 8'd2, {4{32'hCAFE_F00D}}, '1, "awlen_wr");
      rd(1'b1, 32'h8000_0020, 8'd0, "awlen_rd");

      // Bad read length: SLVERR, rdata 0
      rd(1'b0, 32'h8000_0010, 8'd3, "arlen");

      // Below BASE: DECERR with range check, wraps to word 0 without
      rd(1'b1, 32'h0000_0000, 8'd0, "range_rd");
      wr(1'b0, 32'h0000_0030, 8'd0, {4{32'h1234_5678}}, '1, "range_wr");
      rd(1'b0, 32'h8000_0030, 8'd0, "range_chk");

      // rready held low: response stays stable, no new AR accepted
      @(negedge clk);
      bus.arvalid = 1'b1; bus.arid = 1'b1; bus.araddr = 32'h8000_0010; bus.arlen = 8'd0;
      #1;
      wait_grant("hold", 1);
      push_rd(1'b1, 32'h8000_0010, 8'd0);
      @(negedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         check("hold_rvalid",  bus.rvalid,  1);
         check("hold_rdata",   bus.rdata,   sb[0].data);
         check("hold_rid",     bus.rid,     sb[0].id);
         check("hold_rresp",   bus.rresp,   sb[0].resp);
         check("hold_arready", bus.arready, 0);
         @(negedge clk); #1;
      end
      bus.arvalid = 1'b0;
      collect("hold");

      // Contention: alternates READ, WRITE, READ, WRITE from reset
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      bus.arvalid = 1'b1; bus.arid = 1'b0; bus.araddr = 32'h8000_0010; bus.arlen = 8'd0;
      bus.awvalid = 1'b1; bus.awid = 1'b1; bus.awaddr = 32'h8000_0020; bus.awlen = 8'd0;
      bus.wvalid  = 1'b1; bus.wdata = {4{32'hA5A5_5A5A}}; bus.wstrb = '1; bus.wlast = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("cont_arready", bus.arready, (k % 2) == 0);
         check("cont_awready", bus.awready, (k % 2) == 1);
         check("cont_wready",  bus.wready,  (k % 2) == 1);
         if ((k % 2) == 0) push_rd(1'b0, 32'h8000_0010, 8'd0);
         else              push_wr(1'b1, 32'h8000_0020, 8'd0, {4{32'hA5A5_5A5A}}, '1);
         @(negedge clk);
         if (k == 3) begin
            bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
         end
         #1;
         check("cont_latency", (k % 2) == 0 ? bus.rvalid : bus.bvalid, 1);
         collect("cont");
      end
      rd(1'b1, 32'h8000_0020, 8'd0, "cont_rdback");

      // AW ahead of W by 3 cycles: nothing accepted until both are present
      @(negedge clk);
      bus.awvalid = 1'b1; bus.awid = 1'b1; bus.awaddr = 32'h8000_0030; bus.awlen = 8'd0;
      #1;
      for (int c = 0; c < 3; c++) begin
         check("awonly_awready", bus.awready, 0);
         check("awonly_wready",  bus.wready,  0);
         @(negedge clk); #1;
      end
      bus.wvalid = 1'b1; bus.wdata = {4{32'h0BAD_F00D}}; bus.wstrb = '1; bus.wlast = 1'b1;
      #1;
      check("awonly_join_awready", bus.awready, 1);
      check("awonly_join_wready",  bus.wready,  1);
      push_wr(1'b1, 32'h8000_0030, 8'd0, {4{32'h0BAD_F00D}}, '1);
      @(negedge clk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      #1;
      check("awonly_latency", bus.bvalid, 1);
      collect("awonly");

      // Reset while bvalid: response dropped, committed write survives
      issue_wr(1'b0, 32'h8000_0030, 8'd0, {4{32'h7777_1111}}, '1, "rstmid");
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_bvalid", bus.bvalid, 0);
      check("rstmid_bresp",  bus.bresp,  0);
      dropped = sb.pop_front();
      @(negedge clk);
      rst_n = 1'b1;
      rd(1'b1, 32'h8000_0030, 8'd0, "rstmid_rd");

      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
